aes128e_mask_frontend: RTL and testbench

Host-side masking/unmasking front end for the masked AES-128 encryption core. The core computes only on masked, share-split data; this block is the other end of that interface. It draws fresh randomness per block, masks and share-splits plaintext and key, and drives the core's start handshake. It then removes the mask from the core's output and presents the unmasked ciphertext on a valid/ready host port.

---
 rtl/aes128e_mask_frontend_if.sv | 51 +++++
 rtl/aes128e_mask_frontend.sv | 148 ++++++++++++++
 tb/tb_aes128e_mask_frontend.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/aes128e_mask_frontend_if.sv
// Host/TRNG/core-facing signal bundle for the AES-128 masking front end.
interface aes128e_mask_frontend_if #(
  parameter int unsigned L  = 8,
  parameter int unsigned RW = 32
);
  localparam int unsigned DW = 16 * L;

  // host plaintext/key port
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] pt_i;
  logic [DW-1:0] key_i;
  // host ciphertext port
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] ct_o;
  // TRNG port
  logic [RW-1:0] rnd_i;
  logic          rnd_valid_i;
  logic          rnd_ready_o;
  // masked core port
  logic          core_start_o;
  logic [DW-1:0] core_state_o;
  logic [DW-1:0] core_key_o;
  logic [DW-1:0] core_state_share2_o;
  logic [DW-1:0] core_key_share2_o;
  logic          core_ready_i;
  logic          core_unmask_i;
  logic [DW-1:0] core_state_i;
  // key erase
  logic          key_destruct_i;
  logic          core_key_destruct_o;

  // environment side: host, TRNG and core
  modport master (
    output in_valid_i, pt_i, key_i, out_ready_i, rnd_i, rnd_valid_i,
           core_ready_i, core_unmask_i, core_state_i, key_destruct_i,
    input  in_ready_o, out_valid_o, ct_o, rnd_ready_o, core_start_o,
           core_state_o, core_key_o, core_state_share2_o, core_key_share2_o,
           core_key_destruct_o
  );

  // front end side
  modport slave (
    input  in_valid_i, pt_i, key_i, out_ready_i, rnd_i, rnd_valid_i,
           core_ready_i, core_unmask_i, core_state_i, key_destruct_i,
    output in_ready_o, out_valid_o, ct_o, rnd_ready_o, core_start_o,
           core_state_o, core_key_o, core_state_share2_o, core_key_share2_o,
           core_key_destruct_o
  );
endinterface

// File: rtl/aes128e_mask_frontend.sv
// Masking/unmasking front end for the masked AES-128 encryption core:
// fills a randomness pool, masks and share-splits each block, starts the
// core, then unmasks its result onto a valid/ready host port.
module aes128e_mask_frontend #(
  parameter int unsigned L  = 8,
  parameter int unsigned RW = 32
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  aes128e_mask_frontend_if.slave bus
);

  localparam int unsigned DW = 16 * L;
  localparam int unsigned PB = 33 * L;               // pool bits actually used
  localparam int unsigned NW = (PB + RW - 1) / RW;   // TRNG words per fill
  localparam int unsigned PW = NW * RW;              // raw pool width
  localparam int unsigned CW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [2:0] {FILL, ARMED, START, BUSY, DRAIN, FLUSH} state_t;

  state_t        state;
  logic [PW-1:0] pool;
  logic [CW-1:0] cnt;
  logic [DW-1:0] core_state_q;
  logic [DW-1:0] core_key_q;
  logic [DW-1:0] share2_st_q;
  logic [DW-1:0] share2_k_q;
  logic [DW-1:0] ct_q;
  logic          out_valid_q;
  logic          core_start_q;
  logic          key_destruct_q;

  logic [DW-1:0] s_st;
  logic [DW-1:0] s_k;
  logic [L-1:0]  m;
  logic [DW-1:0] m_rep;

  // Pool fields: two shares plus one mask byte replicated across all lanes
  assign s_st  = pool[0 +: DW];
  assign s_k   = pool[DW +: DW];
  assign m     = pool[2*DW +: L];
  assign m_rep = {16{m}};

  // Tail of the last TRNG word beyond the used fields is deliberately dropped
  generate
    if (PW > PB) begin : g_pool_tail
      logic unused_pool_tail;
      assign unused_pool_tail = ^pool[PW-1:PB];
    end
  endgenerate

  // Front-end FSM with all datapath registers; key erase overrides everything
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state          <= FILL;
      pool           <= '0;
      cnt            <= '0;
      core_state_q   <= '0;
      core_key_q     <= '0;
      share2_st_q    <= '0;
      share2_k_q     <= '0;
      ct_q           <= '0;
      out_valid_q    <= 1'b0;
      core_start_q   <= 1'b0;
      key_destruct_q <= 1'b0;
    end else begin
      key_destruct_q <= bus.key_destruct_i;
      if (bus.key_destruct_i) begin
        pool         <= '0;
        cnt          <= '0;
        core_state_q <= '0;
        core_key_q   <= '0;
        share2_st_q  <= '0;
        share2_k_q   <= '0;
        ct_q         <= '0;
        out_valid_q  <= 1'b0;
        core_start_q <= 1'b0;
        // a core that may still be working must be waited out
        state <= (state == START || state == BUSY) ? FLUSH : FILL;
      end else begin
        case (state)
          FILL: begin
            if (bus.rnd_valid_i) begin
              for (int k = 0; k < int'(NW); k++) begin
                if (cnt == CW'(k)) pool[k*RW +: RW] <= bus.rnd_i;
              end
              if (cnt == CW'(NW - 1)) begin
                cnt   <= '0;
                state <= ARMED;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          ARMED: begin
            if (bus.in_valid_i && bus.core_ready_i) begin
              core_state_q <= bus.pt_i ^ m_rep ^ s_st;
              core_key_q   <= bus.key_i ^ m_rep ^ s_k;
              share2_st_q  <= s_st;
              share2_k_q   <= s_k;
              core_start_q <= 1'b1;
              state        <= START;
            end
          end
          START: begin
            core_start_q <= 1'b0;
            state        <= BUSY;
          end
          BUSY: begin
            if (bus.core_unmask_i) begin
              ct_q         <= bus.core_state_i ^ m_rep;
              out_valid_q  <= 1'b1;
              core_state_q <= '0;
              core_key_q   <= '0;
              share2_st_q  <= '0;
              share2_k_q   <= '0;
              pool         <= '0;
              state        <= DRAIN;
            end
          end
          DRAIN: begin
            if (bus.out_ready_i) begin
              ct_q        <= '0;
              out_valid_q <= 1'b0;
              state       <= FILL;
            end
          end
          FLUSH: begin
            if (bus.core_ready_i) state <= FILL;
          end
          default: state <= FILL;
        endcase
      end
    end
  end

  assign bus.in_ready_o          = (state == ARMED) && bus.core_ready_i;
  assign bus.rnd_ready_o         = (state == FILL);
  assign bus.out_valid_o         = out_valid_q;
  assign bus.ct_o                = ct_q;
  assign bus.core_start_o        = core_start_q;
  assign bus.core_state_o        = core_state_q;
  assign bus.core_key_o          = core_key_q;
  assign bus.core_state_share2_o = share2_st_q;
  assign bus.core_key_share2_o   = share2_k_q;
  assign bus.core_key_destruct_o = key_destruct_q;

endmodule

// File: tb/tb_aes128e_mask_frontend.sv
// Directed bench for aes128e_mask_frontend; the bench plays host, TRNG and
// a behavioural core that returns the FIPS-197 ciphertext under mask M.
module tb_aes128e_mask_frontend;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] A5  = {16{8'ha5}};

  // pool 2: random shares, m = 0x00 (upper word bits are discarded)
  localparam logic [287:0] POOL2 = {32'h5a5a5a00, 32'h44444444, 32'h33333333,
                                    32'h22222222, 32'h11111111, 32'hcafef00d,
                                    32'hdeadbeef, 32'h89abcdef, 32'h01234567};
  localparam logic [127:0] SST2  = 128'hcafef00d_deadbeef_89abcdef_01234567;
  localparam logic [127:0] SK2   = 128'h44444444_33333333_22222222_11111111;

  // pool 3: different shares, m = 0x3c
  localparam logic [287:0] POOL3 = {32'hffffff3c, 32'h0f0f0f0f, 32'hf0f0f0f0,
                                    32'h13579bdf, 32'h2468ace0, 32'h76543210,
                                    32'hfedcba98, 32'h0badf00d, 32'h600dcafe};
  localparam logic [127:0] SST3  = 128'h76543210_fedcba98_0badf00d_600dcafe;
  localparam logic [127:0] SK3   = 128'h0f0f0f0f_f0f0f0f0_13579bdf_2468ace0;
  localparam logic [127:0] M3    = {16{8'h3c}};

  logic clk  = 1'b0;
  logic arst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  aes128e_mask_frontend_if #(.L(8), .RW(32)) bus ();

  aes128e_mask_frontend #(.L(8), .RW(32)) dut (
    .clk_i  (clk),
    .arst_i (arst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // feed words first..last of a pool image, optionally with idle gaps carrying junk
  task automatic fill_words(input logic [287:0] w, input bit gaps, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      if (gaps) begin
        bus.rnd_valid_i = 1'b0;
        bus.rnd_i       = 32'hbaadbaad;
        step();
        check("rnd_ready_fill", bus.rnd_ready_o, 1'b1);
      end
      check("in_ready_fill", bus.in_ready_o, 1'b0);
      bus.rnd_i       = w[32*k +: 32];
      bus.rnd_valid_i = 1'b1;
      step();
    end
    bus.rnd_valid_i = 1'b0;
  endtask

  task automatic send_block();
    bus.pt_i       = PT;
    bus.key_i      = KEY;
    bus.in_valid_i = 1'b1;
    step();
    bus.in_valid_i = 1'b0;
  endtask

  task automatic check_core_zero(input string tag);
    check({tag, "_core_state"}, bus.core_state_o, '0);
    check({tag, "_core_key"},   bus.core_key_o, '0);
    check({tag, "_share2_st"},  bus.core_state_share2_o, '0);
    check({tag, "_share2_k"},   bus.core_key_share2_o, '0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  bus.in_ready_o, 1'b0);
    check({tag, "_out_valid"}, bus.out_valid_o, 1'b0);
    check({tag, "_ct"},        bus.ct_o, '0);
    check({tag, "_rnd_ready"}, bus.rnd_ready_o, 1'b1);
    check({tag, "_start"},     bus.core_start_o, 1'b0);
    check({tag, "_kd"},        bus.core_key_destruct_o, 1'b0);
    check_core_zero(tag);
  endtask

  initial begin
    bus.in_valid_i     = 1'b0;
    bus.pt_i           = '0;
    bus.key_i          = '0;
    bus.out_ready_i    = 1'b0;
    bus.rnd_i          = '0;
    bus.rnd_valid_i    = 1'b0;
    bus.core_ready_i   = 1'b1;
    bus.core_unmask_i  = 1'b0;
    bus.core_state_i   = '0;
    bus.key_destruct_i = 1'b0;

    // reset
    #2 arst = 1'b1;
    step();
    step();
    check_reset_vals("rst");
    arst = 1'b0;
    step();

    // block 1: A5 pool fed every other cycle, M = A5 cancels s_st/s_k
    fill_words({9{32'ha5a5a5a5}}, 1'b1, 0, 7);
    check("pre9_in_ready", bus.in_ready_o, 1'b0);
    check("pre9_rnd_ready", bus.rnd_ready_o, 1'b1);
    fill_words({9{32'ha5a5a5a5}}, 1'b1, 8, 8);
    check("armed_in_ready", bus.in_ready_o, 1'b1);
    check("armed_rnd_ready", bus.rnd_ready_o, 1'b0);
    send_block();
    check("b1_start", bus.core_start_o, 1'b1);
    check("b1_core_state", bus.core_state_o, PT);
    check("b1_core_key", bus.core_key_o, KEY);
    check("b1_share2_st", bus.core_state_share2_o, A5);
    check("b1_share2_k", bus.core_key_share2_o, A5);
    check("b1_in_ready_start", bus.in_ready_o, 1'b0);
    step();
    check("b1_start_off", bus.core_start_o, 1'b0);
    repeat (3) step();
    check("b1_busy_share2_st", bus.core_state_share2_o, A5);
    check("b1_busy_out_valid", bus.out_valid_o, 1'b0);
    bus.core_state_i  = CT ^ A5;
    bus.core_unmask_i = 1'b1;
    step();
    bus.core_unmask_i = 1'b0;
    bus.core_state_i  = '0;
    check("b1_out_valid", bus.out_valid_o, 1'b1);
    check("b1_ct", bus.ct_o, CT);
    check_core_zero("b1_unmask");

    // host stall for 20 cycles with host and TRNG offering data
    bus.in_valid_i  = 1'b1;
    bus.rnd_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("stall_out_valid", bus.out_valid_o, 1'b1);
      check("stall_ct", bus.ct_o, CT);
      check("stall_in_ready", bus.in_ready_o, 1'b0);
      check("stall_rnd_ready", bus.rnd_ready_o, 1'b0);
    end
    bus.in_valid_i  = 1'b0;
    bus.rnd_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    step();
    bus.out_ready_i = 1'b0;
    check("b1_drain_out_valid", bus.out_valid_o, 1'b0);
    check("b1_drain_ct", bus.ct_o, '0);
    check("b1_drain_rnd_ready", bus.rnd_ready_o, 1'b1);

    // block 2: random shares, m = 0
    fill_words(POOL2, 1'b0, 0, 8);
    check("b2_in_ready", bus.in_ready_o, 1'b1);
    send_block();
    check("b2_core_state", bus.core_state_o, PT ^ SST2);
    check("b2_core_key", bus.core_key_o, KEY ^ SK2);
    check("b2_share2_st", bus.core_state_share2_o, SST2);
    check("b2_share2_k", bus.core_key_share2_o, SK2);
    step();
    step();
    bus.core_state_i  = CT;
    bus.core_unmask_i = 1'b1;
    step();
    bus.core_unmask_i = 1'b0;
    check("b2_ct", bus.ct_o, CT);
    check("b2_out_valid", bus.out_valid_o, 1'b1);
    bus.out_ready_i = 1'b1;
    step();
    bus.out_ready_i = 1'b0;
    check("b2_drain_out_valid", bus.out_valid_o, 1'b0);

    // key erase 5 cycles after start, aborted result must not surface
    fill_words({9{32'ha5a5a5a5}}, 1'b0, 0, 8);
    send_block();
    check("kd_start", bus.core_start_o, 1'b1);
    bus.core_ready_i = 1'b0;
    repeat (5) step();
    bus.key_destruct_i = 1'b1;
    step();
    bus.key_destruct_i = 1'b0;
    check("kd_pulse", bus.core_key_destruct_o, 1'b1);
    check_core_zero("kd");
    check("kd_ct", bus.ct_o, '0);
    check("kd_rnd_ready", bus.rnd_ready_o, 1'b0);
    check("kd_in_ready", bus.in_ready_o, 1'b0);
    step();
    check("kd_pulse_end", bus.core_key_destruct_o, 1'b0);
    bus.core_state_i  = CT;
    bus.core_unmask_i = 1'b1;
    step();
    bus.core_unmask_i = 1'b0;
    check("flush_out_valid", bus.out_valid_o, 1'b0);
    check("flush_ct", bus.ct_o, '0);
    check("flush_rnd_ready", bus.rnd_ready_o, 1'b0);
    bus.core_ready_i = 1'b1;
    step();
    check("flush_exit_rnd_ready", bus.rnd_ready_o, 1'b1);

    // block 3: m = 0x3c, then async reset while in DRAIN
    fill_words(POOL3, 1'b0, 0, 8);
    send_block();
    check("b3_core_state", bus.core_state_o, PT ^ SST3 ^ M3);
    check("b3_core_key", bus.core_key_o, KEY ^ SK3 ^ M3);
    step();
    bus.core_state_i  = CT ^ M3;
    bus.core_unmask_i = 1'b1;
    step();
    bus.core_unmask_i = 1'b0;
    check("b3_ct", bus.ct_o, CT);
    check("b3_out_valid", bus.out_valid_o, 1'b1);
    step();
    arst = 1'b1;
    #1;
    check_reset_vals("arst");
    #1 arst = 1'b0;
    step();
    check("post_arst_rnd_ready", bus.rnd_ready_o, 1'b1);
    check("post_arst_in_ready", bus.in_ready_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
